// File: rtl/cpu_run_ctrl.sv
// Run/step/dump sequencer: gates the CPU clock-enable, counts executed cycles,
// and streams the 32 register-file entries out after a stop. Define RUN_CTRL_BKPT_EN for the PC breakpoint.
module cpu_run_ctrl #(
  parameter int MAX_CYCLES = 1200,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic [31:0]      pc,
  input  logic [31:0]      bkpt_addr,
  output logic             cpu_en,
  output logic [4:0]       dbg_raddr,
  input  logic [31:0]      dbg_rdata,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [4:0]       dump_idx,
  output logic [31:0]      dump_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [2:0]       state,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_STEP = 3'd2,
    S_DUMP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

  state_t state_q;
  logic   stop_hit;
  logic   cnt_sat;

`ifdef RUN_CTRL_BKPT_EN
  assign stop_hit = halt_req || (pc == bkpt_addr);
`else
  logic unused_bkpt;
  assign unused_bkpt = ^{pc, bkpt_addr};
  assign stop_hit    = halt_req;
`endif

  // A stop request squashes the enable in the same cycle, so the instruction at pc never commits.
  assign cpu_en    = (state_q == S_STEP) || ((state_q == S_RUN) && !stop_hit);
  assign cnt_sat   = (cycle_cnt == MAX_CNT);
  assign dbg_raddr = dump_idx;
  assign dump_data = dbg_rdata;
  assign state     = state_q;

  // NOTE: every register here is written with <= so all updates see pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cycle_cnt  <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= 5'd0;
      done       <= 1'b0;
    end else begin
      if (cpu_en && !cnt_sat)
        cycle_cnt <= cycle_cnt + CNT_W'(1);

      case (state_q)
        S_IDLE, S_HALT: begin
          // Once the limit is reached the block is parked until reset.
          if (!cnt_sat) begin
            if (start) begin
              state_q <= S_RUN;
              done    <= 1'b0;
            end else if (step) begin
              state_q <= S_STEP;
              done    <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (stop_hit || (cycle_cnt >= LAST_CNT)) begin
            state_q    <= S_DUMP;
            dump_valid <= 1'b1;
          end
        end
        S_STEP: begin
          state_q    <= S_DUMP;
          dump_valid <= 1'b1;
        end
        S_DUMP: begin
          if (dump_ready) begin
            dump_idx <= dump_idx + 5'd1;
            if (dump_idx == 5'd31) begin
              state_q    <= S_HALT;
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          dump_valid <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboard bench for cpu_run_ctrl (MAX_CYCLES=8): run, step with throttled dump,
// halt request, reset mid-dump and, with RUN_CTRL_BKPT_EN, the breakpoint stop.
module tb_cpu_run_ctrl;
  localparam int MAX_CYCLES = 8;
  localparam int CNT_W      = 16;

  logic             clk_in = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             step = 1'b0;
  logic             halt_req = 1'b0;
  logic [31:0]      pc = 32'h0040_0000;
  logic [31:0]      bkpt_addr = 32'hFFFF_FFFC;
  logic             cpu_en;
  logic [4:0]       dbg_raddr;
  logic [31:0]      dbg_rdata;
  logic             dump_valid;
  logic             dump_ready = 1'b1;
  logic [4:0]       dump_idx;
  logic [31:0]      dump_data;
  logic [CNT_W-1:0] cycle_cnt;
  logic [2:0]       state;
  logic             done;

  logic [31:0] rf [32];
  assign dbg_rdata = rf[dbg_raddr];

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];

  int total = 0;
  int bad   = 0;

  cpu_run_ctrl #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .reset(reset), .start(start), .step(step),
    .halt_req(halt_req), .pc(pc), .bkpt_addr(bkpt_addr), .cpu_en(cpu_en),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .cycle_cnt(cycle_cnt), .state(state), .done(done)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fill_rf(input logic [31:0] seed);
    for (int i = 0; i < 32; i++) rf[i] = seed + 32'(i) * 32'h0101_0007;
  endtask

  task automatic push_dump();
    beat_t b;
    for (int i = 0; i < 32; i++) begin
      b.idx  = 5'(i);
      b.data = rf[i];
      exp_q.push_back(b);
    end
  endtask

  task automatic do_reset();
    dump_ready = 1'b1;
    halt_req   = 1'b0;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(posedge clk_in); #1;
    reset = 1'b1;
  endtask

  task automatic pulse(input bit is_step);
    @(posedge clk_in); #1;
    if (is_step) step = 1'b1;
    else         start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    step  = 1'b0;
  endtask

  task automatic run_to_halt(input int budget, output int en_n, output int busy_n, output bit ok);
    en_n = 0; busy_n = 0; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_in);
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (cpu_en) en_n++;
      if (state == 3'd1 || state == 3'd3) busy_n++;
    end
  endtask

  // Simple CPU PC model: advances by 4 on every committed cycle.
  initial begin : cpu_model
    logic en_s, rst_s;
    forever begin
      @(negedge clk_in);
      en_s  = cpu_en;
      rst_s = reset;
      @(posedge clk_in); #1;
      if (!rst_s)    pc = 32'h0040_0000;
      else if (en_s) pc = pc + 32'd4;
    end
  end

  initial begin : monitor
    bit          held;
    logic [4:0]  h_idx;
    logic [31:0] h_data;
    beat_t       b;
    held = 1'b0;
    forever begin
      @(negedge clk_in);
      if (dump_valid) begin
        if (held) begin
          check("hold_idx", 32'(dump_idx), 32'(h_idx));
          check("hold_data", dump_data, h_data);
        end
        if (dump_ready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: unexpected beat idx=%0d data=0x%08h", dump_idx, dump_data);
          end else begin
            b = exp_q.pop_front();
            check("beat_idx", 32'(dump_idx), 32'(b.idx));
            check("beat_data", dump_data, b.data);
          end
        end else begin
          held   = 1'b1;
          h_idx  = dump_idx;
          h_data = dump_data;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int en_n, busy_n, dump_cyc;
    bit ok, ph, found;

    // Reset state
    fill_rf(32'h1000_0000);
    reset = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_cnt", 32'(cycle_cnt), 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_idx", 32'(dump_idx), 32'd0);
    check("rst_raddr", 32'(dbg_raddr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", dump_data, rf[0]);
    reset = 1'b1;

    // Free run to the cycle limit, dump with ready tied high
    push_dump();
    pulse(1'b0);
    run_to_halt(200, en_n, busy_n, ok);
    check("run_finished", 32'(ok), 32'd1);
    check("run_en_cycles", 32'(en_n), 32'd8);
    check("run_busy_cycles", 32'(busy_n), 32'd40);
    check("run_cnt", 32'(cycle_cnt), 32'd8);
    check("run_state", 32'(state), 32'd4);
    check("run_done", 32'(done), 32'd1);
    check("run_drained", 32'(exp_q.size()), 32'd0);

    // start/step in HALT at the limit are ignored
    pulse(1'b0);
    en_n = 0;
    repeat (3) begin
      @(negedge clk_in);
      if (cpu_en) en_n++;
    end
    pulse(1'b1);
    @(negedge clk_in);
    if (cpu_en) en_n++;
    check("sat_state", 32'(state), 32'd4);
    check("sat_en", 32'(en_n), 32'd0);
    check("sat_cnt", 32'(cycle_cnt), 32'd8);
    check("sat_done", 32'(done), 32'd1);

    // Single step, then dump with ready alternating 0/1
    do_reset();
    fill_rf(32'hC0DE_0000);
    push_dump();
    pulse(1'b1);
    check("step_state", 32'(state), 32'd2);
    ph = 1'b0; en_n = 0; dump_cyc = 0; ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_in);
      if (cpu_en) en_n++;
      @(posedge clk_in); #1;
      if (state == 3'd4) begin
        ok = 1'b1;
        break;
      end
      if (state == 3'd3) begin
        dump_ready = ph;
        ph = ~ph;
        dump_cyc++;
      end
    end
    dump_ready = 1'b1;
    check("step_finished", 32'(ok), 32'd1);
    check("step_en_cycles", 32'(en_n), 32'd1);
    check("step_cnt", 32'(cycle_cnt), 32'd1);
    check("step_dump_cycles", 32'(dump_cyc), 32'd64);
    check("step_done", 32'(done), 32'd1);
    check("step_drained", 32'(exp_q.size()), 32'd0);

    // halt_req in the 4th RUN cycle
    do_reset();
    fill_rf(32'h5A5A_0000);
    push_dump();
    pulse(1'b0);
    en_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      if (cpu_en) en_n++;
      @(posedge clk_in); #1;
    end
    halt_req = 1'b1;
    @(negedge clk_in);
    check("hreq_state_run", 32'(state), 32'd1);
    check("hreq_en", 32'(cpu_en), 32'd0);
    @(posedge clk_in); #1;
    halt_req = 1'b0;
    check("hreq_next_state", 32'(state), 32'd3);
    check("hreq_cnt", 32'(cycle_cnt), 32'd3);
    check("hreq_en_cycles", 32'(en_n), 32'd3);
    run_to_halt(200, en_n, busy_n, ok);
    check("hreq_finished", 32'(ok), 32'd1);
    check("hreq_drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a dump
    do_reset();
    fill_rf(32'h0BAD_F00D);
    push_dump();
    pulse(1'b0);
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_in);
      if (dump_valid && dump_idx == 5'd10) begin
        reset = 1'b0;
        found = 1'b1;
        break;
      end
    end
    @(posedge clk_in); #1;
    check("mrst_found", 32'(found), 32'd1);
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_valid", 32'(dump_valid), 32'd0);
    check("mrst_idx", 32'(dump_idx), 32'd0);
    check("mrst_cnt", 32'(cycle_cnt), 32'd0);
    check("mrst_cpu_en", 32'(cpu_en), 32'd0);
    check("mrst_beats_left", 32'(exp_q.size()), 32'd21);
    exp_q.delete();
    reset = 1'b1;

`ifdef RUN_CTRL_BKPT_EN
    // Breakpoint stop at 0x00400010
    do_reset();
    bkpt_addr = 32'h0040_0010;
    fill_rf(32'h7777_0000);
    push_dump();
    pulse(1'b0);
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      if (state == 3'd1 && !cpu_en) begin
        found = 1'b1;
        break;
      end
    end
    check("bkpt_found", 32'(found), 32'd1);
    check("bkpt_pc", pc, 32'h0040_0010);
    check("bkpt_cnt", 32'(cycle_cnt), 32'd4);
    @(posedge clk_in); #1;
    check("bkpt_next_state", 32'(state), 32'd3);
    run_to_halt(200, en_n, busy_n, ok);
    check("bkpt_finished", 32'(ok), 32'd1);
    check("bkpt_drained", 32'(exp_q.size()), 32'd0);
    bkpt_addr = 32'hFFFF_FFFC;
`endif

    repeat (2) @(posedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step/dump sequencer for the single-cycle CPU core. It sits beside `sccomp_dataflow` and gates execution through a clock-enable. It counts executed cycles against a hard limit, stops on halt request or PC breakpoint, and then scans all 32 register-file entries out through a valid/ready stream. This gives hardware the same run-N-cycles-then-dump-state flow the team uses in simulation.

## Interface
Parameters:
- `MAX_CYCLES`, 1200: executed-cycle limit; RUN stops after this many enabled cycles.
- `CNT_W`, 16: width of `cycle_cnt`; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
- `clk_in`  in  1  core clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  level; begin/resume free-running execution.
- `step`  in  1  level; execute exactly one cycle.
- `halt_req`  in  1  stop free-running execution.
- `pc`  in  32  current CPU PC.
- `bkpt_addr`  in  32  breakpoint PC; used only with `RUN_CTRL_BKPT_EN`.
- `cpu_en`  out  1  CPU clock-enable; the CPU commits state only when high.
- `dbg_raddr`  out  5  register-file debug read address.
- `dbg_rdata`  in  32  register-file debug read data, combinational from `dbg_raddr`.
- `dump_valid`  out  1  dump beat valid.
- `dump_ready`  in  1  dump beat accepted.
- `dump_idx`  out  5  register index of the current beat.
- `dump_data`  out  32  register value of the current beat.
- `cycle_cnt`  out  CNT_W  executed-cycle count, saturating.
- `state`  out  3  FSM state: IDLE=0, RUN=1, STEP=2, DUMP=3, HALT=4.
- `done`  out  1  high in HALT.

## Operation
- **IDLE:** `cpu_en`=0.
  - `start` → RUN; else `step` → STEP. `start` wins if both are high.
- **RUN:** `cpu_en`=1 unless gated by a stop condition.
  - Stop conditions are evaluated combinationally in the current cycle: `halt_req`=1, or a breakpoint hit (`pc`==`bkpt_addr`).
  - On a stop condition: `cpu_en`=0 that same cycle, the instruction at `pc` is not executed, and next state is DUMP.
  - Otherwise, when `cycle_cnt`==MAX_CYCLES-1: `cpu_en`=1, the count reaches MAX_CYCLES, and next state is DUMP.
- **STEP:** `cpu_en`=1 for exactly one cycle, then → DUMP. No stop-condition gating applies.
- **DUMP:**
  - `cpu_en`=0, `dump_valid`=1.
  - `dbg_raddr`=`dump_idx`; `dump_data`=`dbg_rdata`.
  - `dump_idx` advances on `dump_valid`&&`dump_ready`.
  - Acceptance at idx 31 → HALT; `dump_idx` wraps to 0.
  - While not accepted, `dump_idx` and `dump_data` are held stable. `dump_data` is stable because the CPU is frozen.
- **HALT:** `done`=1, `cpu_en`=0.
  - `start` → RUN; else `step` → STEP.
  - Both are ignored when `cycle_cnt`==MAX_CYCLES; the block stays in HALT until reset.
- STEP entered from IDLE when `cycle_cnt`==MAX_CYCLES cannot occur; the count is 0 after reset.
- `cycle_cnt` increments in every cycle where `cpu_en`=1 and saturates at MAX_CYCLES. It is never cleared except by reset.
- `halt_req` in IDLE, STEP, DUMP or HALT is ignored.

## Timing
- Reset (`reset`=0 at a clock edge) takes effect at the next edge in any state, including mid-RUN and mid-DUMP.
- Reset values: `state`=IDLE, `cpu_en`=0, `cycle_cnt`=0, `dump_valid`=0, `dump_idx`=0, `dbg_raddr`=0, `dump_data`=`dbg_rdata`, `done`=0.
- `start`/`step` sampled at edge N: `cpu_en`=1 in cycle N+1.
- Free-run of K enabled cycles followed by a full dump with `dump_ready` tied high takes K + 32 cycles in RUN+DUMP. `done`=1 in the cycle after the 32nd beat.
- Dump beats run back-to-back at one per cycle when `dump_ready`=1.
- `cpu_en` is a combinational function of the registered state, `halt_req` and the breakpoint compare. The CPU's cycle ends at the same edge that samples `cpu_en`.

## Configuration
- `RUN_CTRL_BKPT_EN` defined: 32-bit PC comparator present; a breakpoint hit stops RUN as described.
- `RUN_CTRL_BKPT_EN` undefined: `bkpt_addr` port is present but ignored; no comparator logic; RUN stops only on `halt_req` or the cycle limit.

## Test plan
- MAX_CYCLES=8, `dump_ready`=1, pulse `start`:
  - `cpu_en` high exactly 8 cycles; `cycle_cnt`=8.
  - 32 consecutive beats with idx 0..31 and data matching the register file.
  - Then `done`=1, `state`=4.
  - Repeat `start` in HALT → stays in HALT.
- From IDLE, pulse `step`: `cpu_en` high 1 cycle, `cycle_cnt`=1, then DUMP.
- In DUMP, `dump_ready` alternates 0/1 starting at idx 0:
  - Each idx is held while `dump_ready`=0.
  - No index is skipped or duplicated.
  - 64 cycles to HALT.
- `RUN_CTRL_BKPT_EN` defined, `bkpt_addr`=0x00400010, `pc` stepping by 4 from 0x00400000:
  - `cpu_en`=0 in the cycle `pc`=0x00400010; `cycle_cnt`=4; next `state`=3.
- `halt_req` high in the 4th RUN cycle: `cpu_en`=0 that cycle, `cycle_cnt`=3, → DUMP.
- `reset`=0 during DUMP at idx 10: next cycle `state`=0, `dump_valid`=0, `dump_idx`=0, `cycle_cnt`=0.
